limn2600_lsu: RTL and testbench
===============================

LIMN2600_LSU -- requirements
Module: limn2600_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255; max cycles from scheduler issue to completion before a timeout fault.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  CPU presents a load/store request.
REQ-005 req_ready  output  1  LSU can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  00=byte, 01=half, 11=word, 10=reserved.
REQ-009 req_signed  input  1  sign-extend load result.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_data  output  32  load result, extended to 32 bits; 0 for stores and faults.
REQ-013 resp_fault  output  2  00=none, 01=misaligned, 10=timeout, 11=reserved size.
REQ-014 sched_read_addr/size/enable  output  32/2/1  to scheduler client read port.
REQ-015 sched_read_value, sched_read_addr_in, sched_read_rdy  input  32/32/1  from scheduler.
REQ-016 sched_write_addr/value/size/enable  output  32/32/2/1  to scheduler client write port.
REQ-017 sched_write_rdy  input  1  scheduler accepted the write.
REQ-018 sched_full  input  1  scheduler queue full; no issue while high.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP; one request in flight at a time.
REQ-020 IDLE: on req_valid, latch all req_* fields in the same cycle; next state ISSUE.
REQ-021 Alignment check at acceptance: half requires addr[0]=0, word requires addr[1:0]=0, size 10 is reserved; any violation goes straight to RESP with the matching fault and no scheduler traffic.
REQ-022 ISSUE: while sched_full=1, hold in ISSUE with all enables low; otherwise assert exactly one enable for exactly one cycle.
REQ-023 A load drives sched_read_addr = addr & ~3 and size 11, then enters WAIT_RD.
REQ-024 A store drives sched_write_addr = addr, sched_write_value = wdata, sched_write_size = size, then enters WAIT_WR.
REQ-025 WAIT_RD completes only on sched_read_rdy=1 with sched_read_addr_in equal to the issued word address; non-matching returns are ignored.
REQ-026 Load lane extraction: byte lane = addr[1:0]*8, half lane = addr[1]*16; result is zero- or sign-extended per req_signed; word loads pass through unchanged.
REQ-027 WAIT_WR completes on sched_write_rdy=1.
REQ-028 Timeout counter clears on issue and increments in WAIT_*; on reaching TIMEOUT_CYCLES go to RESP with fault 10 and resp_data 0.
REQ-029 A late sched_read_rdy or sched_write_rdy arriving after a timeout, or while in IDLE, is dropped.
REQ-030 RESP: resp_valid=1 for one cycle, then IDLE; resp_data/resp_fault hold until the next RESP.
REQ-031 Minimum latency: an aligned load with immediate rdy responds 3 cycles after acceptance (ISSUE, WAIT_RD, RESP); a misaligned request responds 1 cycle after acceptance.

Reset
REQ-032 On rst: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_fault=00, all sched_*_enable=0, sched addresses/values=0, timeout counter=0.
REQ-033 Reset mid-operation abandons the in-flight request without a response; responses the scheduler delivers later are dropped per REQ-029.

Structure
REQ-034 Size encodings, fault codes and the FSM state enum shall reside in shared package limn2600_pkg.
REQ-035 Lane extraction and extension shall be one combinational sub-module, limn2600_lsu_extract.

Verification
REQ-036 Signed byte load at 0x1003 with returned word 0x80FF_1234 -> resp_data 0xFFFF_FF80, fault 00.
REQ-037 Unsigned half load at 0x2002 with returned word 0xBEEF_0001 -> resp_data 0x0000_BEEF.
REQ-038 Word store at 0x3001 -> resp_fault 01 one cycle after acceptance; sched_write_enable never asserted.
REQ-039 sched_full held high for 10 cycles during a store to 0x4000 -> single write enable only after full drops; resp after sched_write_rdy.
REQ-040 TIMEOUT_CYCLES=8, load with no sched_read_rdy -> resp_fault 10 after 8 WAIT_RD cycles; a late rdy is ignored.
REQ-041 rst asserted during WAIT_RD -> outputs take reset values immediately, no resp_valid pulse, and a subsequent load completes normally.

Source files
------------

// File: rtl/limn2600_pkg.sv
// Shared types for the Limn2600 load/store unit: access sizes, fault codes,
// FSM states and the acceptance-time alignment check.
package limn2600_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10,
    FAULT_SIZE     = 2'b11
  } fault_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_WAIT_WR,
    ST_RESP
  } state_e;

  // A reserved size is reported ahead of any alignment problem.
  function automatic fault_e align_fault(input size_e size, input logic [1:0] lo);
    fault_e f;
    f = FAULT_NONE;
    case (size)
      SZ_HALF: if (lo[0]) f = FAULT_MISALIGN;
      SZ_WORD: if (lo != 2'b00) f = FAULT_MISALIGN;
      SZ_RSVD: f = FAULT_SIZE;
      default: f = FAULT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/limn2600_lsu_if.sv
// CPU request/response and scheduler client ports of the LSU.
// slave is the LSU side; master is the CPU + scheduler side.
interface limn2600_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;

  logic [31:0] sched_read_addr;
  logic [1:0]  sched_read_size;
  logic        sched_read_enable;
  logic [31:0] sched_read_value;
  logic [31:0] sched_read_addr_in;
  logic        sched_read_rdy;

  logic [31:0] sched_write_addr;
  logic [31:0] sched_write_value;
  logic [1:0]  sched_write_size;
  logic        sched_write_enable;
  logic        sched_write_rdy;
  logic        sched_full;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output req_ready, resp_valid, resp_data, resp_fault,
    output sched_read_addr, sched_read_size, sched_read_enable,
    input  sched_read_value, sched_read_addr_in, sched_read_rdy,
    output sched_write_addr, sched_write_value, sched_write_size, sched_write_enable,
    input  sched_write_rdy, sched_full
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_fault,
    input  sched_read_addr, sched_read_size, sched_read_enable,
    output sched_read_value, sched_read_addr_in, sched_read_rdy,
    input  sched_write_addr, sched_write_value, sched_write_size, sched_write_enable,
    output sched_write_rdy, sched_full
  );

endinterface

// File: rtl/limn2600_lsu_extract.sv
// Picks the addressed byte/half out of a returned word and zero- or
// sign-extends it; word loads pass straight through.
module limn2600_lsu_extract
  import limn2600_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    data = word;
    case (size)
      SZ_BYTE: data = sign_ext ? {{24{b[7]}}, b} : {24'b0, b};
      SZ_HALF: data = sign_ext ? {{16{h[15]}}, h} : {16'b0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/limn2600_lsu.sv
// Limn2600 load/store unit: one request in flight, issued to the scheduler
// client ports, with alignment checking and a bounded wait for completion.
module limn2600_lsu
  import limn2600_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  limn2600_lsu_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  size_e       size_q;
  logic        we_q;
  logic        signed_q;
  logic [TW-1:0] timer;

  logic [31:0] word_addr;
  logic [31:0] load_data;
  fault_e      accept_fault;

  assign word_addr    = {addr_q[31:2], 2'b00};
  assign accept_fault = align_fault(size_e'(bus.req_size), bus.req_addr[1:0]);

  limn2600_lsu_extract u_extract (
    .word     (bus.sched_read_value),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (signed_q),
    .data     (load_data)
  );

  // Enables and resp_valid default low so each is a single-cycle pulse;
  // resp_data/resp_fault are only written on the way into RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= ST_IDLE;
      addr_q                 <= '0;
      wdata_q                <= '0;
      size_q                 <= SZ_BYTE;
      we_q                   <= 1'b0;
      signed_q               <= 1'b0;
      timer                  <= '0;
      bus.req_ready          <= 1'b1;
      bus.resp_valid         <= 1'b0;
      bus.resp_data          <= '0;
      bus.resp_fault         <= FAULT_NONE;
      bus.sched_read_addr    <= '0;
      bus.sched_read_size    <= '0;
      bus.sched_read_enable  <= 1'b0;
      bus.sched_write_addr   <= '0;
      bus.sched_write_value  <= '0;
      bus.sched_write_size   <= '0;
      bus.sched_write_enable <= 1'b0;
    end else begin
      bus.resp_valid         <= 1'b0;
      bus.sched_read_enable  <= 1'b0;
      bus.sched_write_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            size_q        <= size_e'(bus.req_size);
            we_q          <= bus.req_we;
            signed_q      <= bus.req_signed;
            bus.req_ready <= 1'b0;
            if (accept_fault != FAULT_NONE) begin
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_fault <= accept_fault;
              state          <= ST_RESP;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (!bus.sched_full) begin
            timer <= '0;
            if (we_q) begin
              bus.sched_write_addr   <= addr_q;
              bus.sched_write_value  <= wdata_q;
              bus.sched_write_size   <= size_q;
              bus.sched_write_enable <= 1'b1;
              state                  <= ST_WAIT_WR;
            end else begin
              bus.sched_read_addr   <= word_addr;
              bus.sched_read_size   <= SZ_WORD;
              bus.sched_read_enable <= 1'b1;
              state                 <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          // Returns for some other word belong to another client.
          if (bus.sched_read_rdy && (bus.sched_read_addr_in == word_addr)) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= load_data;
            bus.resp_fault <= FAULT_NONE;
            state          <= ST_RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_fault <= FAULT_TIMEOUT;
            state          <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_WR: begin
          if (bus.sched_write_rdy) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_fault <= FAULT_NONE;
            state          <= ST_RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_fault <= FAULT_TIMEOUT;
            state          <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_limn2600_lsu.sv
// Directed bench for limn2600_lsu: lane extraction, faults, back-pressure,
// timeout and mid-flight reset, with latencies counted from acceptance.
module tb_limn2600_lsu;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  limn2600_lsu_if bus ();

  limn2600_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int resp_pulses = 0;
  int rd_issues = 0;
  int wr_issues = 0;
  int full_issues = 0;
  int expected_pulses = 0;

  logic [31:0] got_data;
  logic [1:0]  got_fault;
  int          got_lat;
  int          snap_rd, snap_wr, snap_resp;

  always @(posedge clk) begin
    if (bus.resp_valid) resp_pulses++;
    if (bus.sched_read_enable) rd_issues++;
    if (bus.sched_write_enable) wr_issues++;
    if (bus.sched_full && (bus.sched_read_enable || bus.sched_write_enable)) full_issues++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // mode: 0 = scheduler never answers, 1 = answer on the enable cycle,
  // 2 = first a return for the wrong word, then the right one.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] wdata, input logic [31:0] rword,
                               input int full_cycles, input int mode);
    int cyc;
    bit done, pending, wrong_left;
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    bus.sched_full = (full_cycles > 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1; done = 0; pending = 0; wrong_left = 0;
    got_lat = -1; got_data = 32'hDEAD_DEAD; got_fault = 2'b00;
    while (!done && cyc < 40) begin
      if (cyc >= full_cycles) bus.sched_full = 1'b0;
      bus.sched_read_rdy  = 1'b0;
      bus.sched_write_rdy = 1'b0;
      if (bus.sched_write_enable && mode != 0) bus.sched_write_rdy = 1'b1;
      if (bus.sched_read_enable && mode != 0) begin
        pending = 1; wrong_left = (mode == 2);
      end
      if (pending) begin
        bus.sched_read_rdy   = 1'b1;
        bus.sched_read_value = rword;
        if (wrong_left) begin
          bus.sched_read_addr_in = waddr ^ 32'h10;
          wrong_left = 0;
        end else begin
          bus.sched_read_addr_in = waddr;
          pending = 0;
        end
      end
      if (bus.resp_valid) begin
        done = 1; got_lat = cyc; got_data = bus.resp_data; got_fault = bus.resp_fault;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.sched_read_rdy  = 1'b0;
    bus.sched_write_rdy = 1'b0;
    bus.sched_full      = 1'b0;
    expected_pulses++;
    checkOutput("resp_within_bound", {31'b0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_wdata = 0;
    bus.sched_read_value = 0; bus.sched_read_addr_in = 0; bus.sched_read_rdy = 0;
    bus.sched_write_rdy = 0; bus.sched_full = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    checkOutput("reset_resp_data", bus.resp_data, 32'd0);
    checkOutput("reset_resp_fault", {30'b0, bus.resp_fault}, 32'd0);
    checkOutput("reset_enables", {30'b0, bus.sched_read_enable, bus.sched_write_enable}, 32'd0);
    checkOutput("reset_read_addr", bus.sched_read_addr, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 32'h1003, 2'b00, 1'b1, 32'h0, 32'h80FF_1234, 0, 1);
    checkOutput("sbyte_data", got_data, 32'hFFFF_FF80);
    checkOutput("sbyte_fault", {30'b0, got_fault}, 32'd0);
    checkOutput("sbyte_latency", got_lat, 32'd3);
    checkOutput("sbyte_sched_addr", bus.sched_read_addr, 32'h1000);
    checkOutput("sbyte_sched_size", {30'b0, bus.sched_read_size}, 32'd3);

    applyStimulus(1'b0, 32'h2002, 2'b01, 1'b0, 32'h0, 32'hBEEF_0001, 0, 1);
    checkOutput("uhalf_data", got_data, 32'h0000_BEEF);

    applyStimulus(1'b0, 32'h1001, 2'b00, 1'b0, 32'h0, 32'h80FF_1234, 0, 1);
    checkOutput("ubyte_lane1_data", got_data, 32'h0000_0012);

    applyStimulus(1'b0, 32'h2000, 2'b01, 1'b1, 32'h0, 32'h1234_8001, 0, 1);
    checkOutput("shalf_lane0_data", got_data, 32'hFFFF_8001);

    applyStimulus(1'b0, 32'h6004, 2'b11, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 2);
    checkOutput("word_wrong_addr_data", got_data, 32'hDEAD_BEEF);
    checkOutput("word_wrong_addr_latency", got_lat, 32'd4);

    applyStimulus(1'b0, 32'h5000, 2'b11, 1'b0, 32'h0, 32'h0, 0, 0);
    checkOutput("timeout_fault", {30'b0, got_fault}, 32'd2);
    checkOutput("timeout_data", got_data, 32'd0);
    checkOutput("timeout_latency", got_lat, 32'd10);
    @(negedge clk);
    snap_resp = resp_pulses;
    bus.sched_read_rdy = 1'b1; bus.sched_read_addr_in = 32'h5000; bus.sched_read_value = 32'h1;
    repeat (3) @(negedge clk);
    bus.sched_read_rdy = 1'b0;
    @(negedge clk);
    checkOutput("late_rdy_dropped", resp_pulses - snap_resp, 32'd0);
    checkOutput("late_rdy_ready", {31'b0, bus.req_ready}, 32'd1);

    snap_wr = wr_issues; snap_rd = rd_issues;
    applyStimulus(1'b1, 32'h3001, 2'b11, 1'b0, 32'h1234_5678, 32'h0, 0, 1);
    checkOutput("misalign_store_fault", {30'b0, got_fault}, 32'd1);
    checkOutput("misalign_store_latency", got_lat, 32'd1);
    checkOutput("misalign_store_data", got_data, 32'd0);
    checkOutput("misalign_no_traffic", (wr_issues - snap_wr) + (rd_issues - snap_rd), 32'd0);

    applyStimulus(1'b0, 32'h0010, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1);
    checkOutput("rsvd_size_fault", {30'b0, got_fault}, 32'd3);
    checkOutput("rsvd_size_latency", got_lat, 32'd1);

    applyStimulus(1'b0, 32'h2001, 2'b01, 1'b0, 32'h0, 32'h0, 0, 1);
    checkOutput("misalign_half_fault", {30'b0, got_fault}, 32'd1);

    snap_wr = wr_issues;
    applyStimulus(1'b1, 32'h4000, 2'b11, 1'b0, 32'hCAFE_F00D, 32'h0, 10, 1);
    @(negedge clk);
    checkOutput("full_store_fault", {30'b0, got_fault}, 32'd0);
    checkOutput("full_store_latency", got_lat, 32'd12);
    checkOutput("full_store_one_enable", wr_issues - snap_wr, 32'd1);
    checkOutput("full_store_no_issue_while_full", full_issues, 32'd0);
    checkOutput("full_store_addr", bus.sched_write_addr, 32'h4000);
    checkOutput("full_store_value", bus.sched_write_value, 32'hCAFE_F00D);
    checkOutput("full_store_size", {30'b0, bus.sched_write_size}, 32'd3);

    applyStimulus(1'b1, 32'h4003, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 0, 1);
    checkOutput("byte_store_latency", got_lat, 32'd3);
    checkOutput("byte_store_addr", bus.sched_write_addr, 32'h4003);
    checkOutput("byte_store_size", {30'b0, bus.sched_write_size}, 32'd0);

    applyStimulus(1'b0, 32'h7000, 2'b00, 1'b1, 32'h0, 32'h0000_007F, 0, 1);
    checkOutput("sbyte_positive_data", got_data, 32'h0000_007F);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h8000;
    bus.req_size = 2'b11; bus.req_signed = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    snap_resp = resp_pulses;
    rst = 1'b1;
    #1;
    checkOutput("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("midrst_resp_data", bus.resp_data, 32'd0);
    checkOutput("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    checkOutput("midrst_read_addr", bus.sched_read_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.sched_read_rdy = 1'b1; bus.sched_read_addr_in = 32'h8000; bus.sched_read_value = 32'h5;
    repeat (2) @(negedge clk);
    bus.sched_read_rdy = 1'b0;
    @(negedge clk);
    checkOutput("midrst_no_resp", resp_pulses - snap_resp, 32'd0);

    applyStimulus(1'b0, 32'h8004, 2'b11, 1'b0, 32'h0, 32'h1122_3344, 0, 1);
    checkOutput("after_rst_data", got_data, 32'h1122_3344);
    checkOutput("after_rst_latency", got_lat, 32'd3);

    repeat (2) @(negedge clk);
    checkOutput("single_cycle_pulses", resp_pulses, expected_pulses);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
